conditional_array_arbiter: RTL
==============================

// Module: conditional_array_arbiter
// PURPOSE
//  Round-robin arbiter sharing one registered ROWS x COLS array output between two requesters (A, B).
//  Each cycle it derives a select bit, muxes the granted requester's array, and loads it into a one-entry output register.
//  Sits upstream of array consumers that accept one matrix per transfer.
//  Uses valid/ready on both input ports and on the output port.
// PARAMETERS
//  BIT_WIDTH  4  width of one array element
//  ROWS       8  array rows
//  COLS       8  array columns
// PORTS
//  clk          input   1                      clock; all state on rising edge
//  rst_n        input   1                      asynchronous active-low reset
//  a_valid      input   1                      requester A presents an array
//  a_ready      output  1                      A transfer accepted this cycle
//  a_data       input   [BIT_WIDTH-1:0][R][C]  requester A array, unpacked [ROWS][COLS]
//  b_valid      input   1                      requester B presents an array
//  b_ready      output  1                      B transfer accepted this cycle
//  b_data       input   [BIT_WIDTH-1:0][R][C]  requester B array, unpacked [ROWS][COLS]
//  out_valid    output  1                      output register holds an array
//  out_ready    input   1                      consumer accepts output
//  out_data     output  [BIT_WIDTH-1:0][R][C]  registered selected array
//  out_src      output  1                      source of out_data: 1 = A, 0 = B
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//  Reset values:
//   - out_valid = 0, out_data = all zeros, out_src = 0.
//   - Internal last_grant = B, so A wins the first tie.
//  Load condition: load = !out_valid | out_ready. This allows full throughput (one array per cycle).
//  Grant (combinational), evaluated only when load = 1:
//   - Only A valid -> A. Only B valid -> B.
//   - Both valid -> the requester that is not last_grant.
//   - Neither valid -> no grant.
//  Ready signals:
//   - a_ready = load & grant_a; b_ready = load & grant_b. Never both 1 in the same cycle.
//   - Ready may depend combinationally on valid and out_ready.
//  Transfer (grant & load), on the next edge:
//   - out_data <= granted array; out_src <= (grant == A).
//   - out_valid <= 1; last_grant <= granter.
//  Output drains with no new grant (out_ready = 1, no valid): out_valid <= 0. out_data and out_src hold their values.
//  Stall (out_valid = 1, out_ready = 0):
//   - out_data, out_src and out_valid are stable.
//   - a_ready = b_ready = 0; last_grant is unchanged.
//  Latency: 1 cycle from the input handshake to out_valid.
//  Input protocol: inputs must hold valid and data until ready. The arbiter does not check this.
//  Reset mid-transfer: the held output is discarded (out_valid -> 0 immediately). No handshake completes in that cycle.
//  States: EMPTY (out_valid = 0) and FULL (out_valid = 1).
//   - EMPTY -> FULL on a grant.
//   - FULL -> FULL on a stall, or on out_ready with a grant.
//   - FULL -> EMPTY on out_ready with no grant.
// CONFIGURATION
//  `CONDITIONAL_ARRAY_ARB_LOCK_EN defined:
//   - Adds ports a_lock and b_lock (input, 1 bit).
//   - While the last_grant requester keeps valid & lock high, it is re-granted ahead of round-robin.
//   - The other requester waits. Lock is sampled in the same cycle as valid.
//   - Lock released, or last_grant requester not valid -> normal round-robin resumes.
//  Not defined: the ports are absent and arbitration is pure round-robin.
// TESTING
//  1. Reset asserted mid-FULL with out_valid = 1 -> out_valid, out_data and out_src go to 0 asynchronously.
//  2. A valid only, data = all 4'h5, out_ready = 1 -> a_ready = 1. Next cycle out_valid = 1, out_data all 4'h5, out_src = 1.
//  3. A and B both valid for 4 cycles, out_ready = 1, first after reset -> grants A, B, A, B.
//     out_src = 1, 0, 1, 0 on consecutive cycles.
//  4. out_ready = 0 for 3 cycles while FULL, A and B valid -> a_ready = b_ready = 0.
//     out_data is stable. After release, the winner is the requester not last granted.
//  5. B only, then idle with out_ready = 1 -> out_valid 1 for one cycle, then 0. out_data retains B's array.
//  6. With LOCK_EN: A granted with a_lock = 1, B valid for 3 cycles -> A, A, A.
//     Drop a_lock -> B is granted next.

Source files
------------

// File: rtl/conditional_array_arbiter_if.sv
// rtl/conditional_array_arbiter_if.sv - two-requester array arbiter bus; lock ports with CONDITIONAL_ARRAY_ARB_LOCK_EN
interface conditional_array_arbiter_if #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
);
  logic                 a_valid;
  logic                 a_ready;
  logic [BIT_WIDTH-1:0] a_data [ROWS][COLS];
  logic                 b_valid;
  logic                 b_ready;
  logic [BIT_WIDTH-1:0] b_data [ROWS][COLS];
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data [ROWS][COLS];
  logic                 out_src;
`ifdef CONDITIONAL_ARRAY_ARB_LOCK_EN
  logic                 a_lock;
  logic                 b_lock;

  modport master (
    output a_valid, a_data, a_lock, b_valid, b_data, b_lock, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
  modport slave (
    input  a_valid, a_data, a_lock, b_valid, b_data, b_lock, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );
`else
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );
`endif
endinterface

// File: rtl/conditional_array_arbiter.sv
// rtl/conditional_array_arbiter.sv - round-robin A/B array arbiter with one-entry output register; optional lock via CONDITIONAL_ARRAY_ARB_LOCK_EN
module conditional_array_arbiter #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  conditional_array_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, next_state;
  logic   last_a_q;     // 1 = A was granted last, 0 = B (reset value, so A wins first tie)
  logic   load;
  logic   pick_a;
  logic   grant_a;
  logic   grant_b;
`ifdef CONDITIONAL_ARRAY_ARB_LOCK_EN
  logic   lock_hold;
`endif

  assign bus.out_valid = (state_q == FULL);

  // Occupancy state register; reset discards any held array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= next_state;
  end

  // Grant selection, ready generation and next occupancy state.
  always_comb begin
    next_state  = state_q;
    pick_a      = 1'b0;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
`ifdef CONDITIONAL_ARRAY_ARB_LOCK_EN
    lock_hold   = last_a_q ? (bus.a_valid & bus.a_lock) : (bus.b_valid & bus.b_lock);
`endif
    load = (state_q == EMPTY) | bus.out_ready;
    // On a tie, the requester that was not granted last wins.
    pick_a = bus.a_valid & (!bus.b_valid | !last_a_q);
`ifdef CONDITIONAL_ARRAY_ARB_LOCK_EN
    if (lock_hold) pick_a = last_a_q;
`endif
    grant_a = load & pick_a;
    grant_b = load & bus.b_valid & !pick_a;
    bus.a_ready = grant_a;
    bus.b_ready = grant_b;
    if (grant_a | grant_b) next_state = FULL;
    else if (load)         next_state = EMPTY;
  end

  // Output register: capture the granted array and its source on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_src <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          bus.out_data[r][c] <= '0;
    end else if (grant_a | grant_b) begin
      bus.out_src <= grant_a;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          bus.out_data[r][c] <= grant_a ? bus.a_data[r][c] : bus.b_data[r][c];
    end
  end

  // Round-robin history: remembers which requester transferred last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_a_q <= 1'b0;
    else if (grant_a) last_a_q <= 1'b1;
    else if (grant_b) last_a_q <= 1'b0;
  end
endmodule
